qspi_read_engine: RTL

Parametrised successor to the single-lane serial flash read sequencer. Issues a flash read command (opcode, address, optional dummy cycles), then shifts data in on 1, 2 or 4 lanes. Assembles the data into bytes and streams them out with a valid strobe. Sits between the memory-interface command layer (start/done handshake) and the QSPI pads (ncs, clock enable, io lanes).

---
 rtl/qspi_read_engine.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_read_engine.sv
// Purpose : QSPI flash read sequencer: opcode + address on io[0], optional dummy clocks,
//           then 1/2/4-lane data capture assembled into bytes.
// Latency : rd_valid trails the last shift cycle of each byte by SYNC_STAGES+1 cycles;
//           done follows the final shift by SYNC_STAGES+1 cycles.
// Backpr. : none; rd_valid is a strobe that the consumer must take when it fires.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start/mode/address/len_bytes   request, latched when accepted in IDLE
//   busy, done            transaction in flight / one-cycle completion pulse
//   ncs, sck_en           chip select (active low), flash clock gate
//   io_out, io_oe, io_in  QSPI lane data out, output enables, data in
//   rd_data, rd_valid     assembled byte (first bit in MSB) and its strobe
//   crc8                  running CRC-8 of the transaction (only with QSPI_RD_CRC_EN)
//
// Optional feature macro: QSPI_RD_CRC_EN adds the crc8 output and its update logic.
module qspi_read_engine #(
   parameter int         ADDR_W      = 24,
   parameter int         LEN_W       = 16,
   parameter int         DUMMY_CYC   = 8,
   parameter logic [7:0] OPC_SINGLE  = 8'h03,
   parameter logic [7:0] OPC_DUAL    = 8'h3B,
   parameter logic [7:0] OPC_QUAD    = 8'h6B,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] address,
   input  logic [LEN_W-1:0]  len_bytes,
   output logic              busy,
   output logic              done,
   output logic              ncs,
   output logic              sck_en,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   input  logic [3:0]        io_in,
   output logic [7:0]        rd_data,
   output logic              rd_valid
`ifdef QSPI_RD_CRC_EN
   ,
   output logic [7:0]        crc8
`endif
);

   // The counter must hold the longest phase: address bits, dummy clocks or
   // single-lane read cycles (8 per byte).
   localparam int RD_W       = LEN_W + 3;
   localparam int AW_B       = $clog2(ADDR_W + 1);
   localparam int DM_B       = $clog2(DUMMY_CYC + 1);
   localparam int CNT_W      = (RD_W >= AW_B && RD_W >= DM_B) ? RD_W :
                               ((AW_B >= DM_B) ? AW_B : DM_B);
   localparam int TX_W       = 8 + ADDR_W;
   localparam int DUMMY_LOAD = (DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_DRAIN, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TX_W-1:0]       tx_q, tx_d;
   logic [1:0]            mode_q, mode_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  accept;
   logic [1:0]            mode_in;
   logic [7:0]            opc_in;
   logic [CNT_W-1:0]      rd_cyc;
   logic                  has_dummy;

   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [SYNC_STAGES-1:0]      cap_q;
   logic                  cap_en;
   logic [3:0]            s_in;
   logic [7:0]            sh_q, sh_d;
   logic [2:0]            bcnt_q;
   logic [3:0]            lanes;
   logic [3:0]            bsum;
   logic                  byte_done;

   // Reserved mode 3 behaves as single-lane.
   assign mode_in   = (mode == 2'd3) ? 2'd0 : mode;
   assign opc_in    = (mode_in == 2'd2) ? OPC_QUAD :
                      (mode_in == 2'd1) ? OPC_DUAL : OPC_SINGLE;
   // Read cycles = len*8/L; mode_q equals log2(L) for the three legal modes.
   assign rd_cyc    = CNT_W'(len_q) << (2'd3 - mode_q);
   assign has_dummy = (mode_q != 2'd0) && (DUMMY_CYC != 0);

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      mode_d  = mode_q;
      len_d   = len_q;
      accept  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               mode_d  = mode_in;
               len_d   = len_bytes;
               tx_d    = {opc_in, address};
               cnt_d   = CNT_W'(7);
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            tx_d = tx_q << 1;
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(ADDR_W - 1);
               state_d = S_ADDR;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ADDR: begin
            tx_d = tx_q << 1;
            if (cnt_q == '0) begin
               if (has_dummy) begin
                  cnt_d   = CNT_W'(DUMMY_LOAD);
                  state_d = S_DUMMY;
               end else if (len_q != '0) begin
                  cnt_d   = rd_cyc - 1'b1;
                  state_d = S_READ;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DUMMY: begin
            if (cnt_q == '0) begin
               if (len_q != '0) begin
                  cnt_d   = rd_cyc - 1'b1;
                  state_d = S_READ;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_READ: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(SYNC_STAGES - 1);
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pad outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tx_q    <= '0;
         mode_q  <= '0;
         len_q   <= '0;
         ncs     <= 1'b1;
         sck_en  <= 1'b0;
         io_out  <= '0;
         io_oe   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
         ncs     <= (state_d == S_IDLE) || (state_d == S_DONE);
         busy    <= (state_d != S_IDLE) && (state_d != S_DONE);
         done    <= (state_d == S_DONE);
         sck_en  <= (state_d == S_CMD) || (state_d == S_ADDR) ||
                    (state_d == S_DUMMY) || (state_d == S_READ);
         if ((state_d == S_CMD) || (state_d == S_ADDR)) begin
            io_oe  <= 4'b0001;
            io_out <= {3'b000, tx_d[TX_W-1]};
         end else begin
            io_oe  <= 4'b0000;
            io_out <= 4'b0000;
         end
      end
   end

   // ---------------- capture path ----------------
   // cap_q delays the READ flag by the synchroniser depth, so cap_en marks the
   // cycle in which s_in holds the sample of a READ shift cycle.
   assign cap_en = cap_q[SYNC_STAGES-1];
   assign s_in   = sync_q[SYNC_STAGES-1];

   always_comb begin
      sh_d  = sh_q;
      lanes = 4'd1;
      unique case (mode_q)
         2'd2: begin
            sh_d  = {sh_q[3:0], s_in[3:0]};
            lanes = 4'd4;
         end
         2'd1: begin
            sh_d  = {sh_q[5:0], s_in[1:0]};
            lanes = 4'd2;
         end
         default: begin
            sh_d  = {sh_q[6:0], s_in[1]};
            lanes = 4'd1;
         end
      endcase
   end

   assign bsum      = {1'b0, bcnt_q} + lanes;
   assign byte_done = cap_en && (bsum == 4'd8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cap_q    <= '0;
         sh_q     <= '0;
         bcnt_q   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         sync_q[0] <= io_in;
         cap_q[0]  <= (state_q == S_READ);
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
            cap_q[i]  <= cap_q[i-1];
         end
         rd_valid <= byte_done;
         if (accept) begin
            bcnt_q <= '0;
         end else if (cap_en) begin
            sh_q   <= sh_d;
            bcnt_q <= bsum[2:0];
         end
         if (byte_done) rd_data <= sh_d;
      end
   end

`ifdef QSPI_RD_CRC_EN
   // CRC-8, poly 0x07, init 0, MSB first; one byte per call.
   function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   // Updated in step with rd_valid so the final byte is folded in by the done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         crc8 <= '0;
      else if (accept)    crc8 <= '0;
      else if (byte_done) crc8 <= crc8_byte(crc8, sh_d);
   end
`endif

endmodule
